// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared state encoding and op constants for muldiv_unit  (rev 1.0)
// ============================================================================
`default_nettype none

package muldiv_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   function automatic int count_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// muldiv_step : one combinational restoring-divide or shift-add-multiply step  (rev 1.0)
// ============================================================================
`default_nettype none

module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             op_div,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH-1:0] hi_next,
   output logic [WIDTH-1:0] lo_next
);

   logic [WIDTH:0] w_shifted;
   logic [WIDTH:0] w_diff;
   logic [WIDTH:0] w_sum;

   // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
   // Multiply: {hi,lo} is the accumulator with the multiplier consumed from lo[0].
   always_comb begin
      w_shifted = {hi, lo[WIDTH-1]};
      w_diff    = w_shifted - {1'b0, opnd};
      w_sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      hi_next   = hi;
      lo_next   = lo;
      if (op_div) begin
         if (w_shifted >= {1'b0, opnd}) begin
            hi_next = w_diff[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_next = w_shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_next = w_sum[WIDTH:1];
         lo_next = {w_sum[0], lo[WIDTH-1:1]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative signed/unsigned multiply/divide with annul  (rev 1.0)
// ============================================================================
`default_nettype none

module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter bit MUL_FAST = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               op_div,
   input  logic               signed_op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               annul,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);

   localparam int CNT_W = count_width(WIDTH);

   state_t               r_state;
   logic [CNT_W-1:0]     r_count;
   logic                 r_op_div;
   logic                 r_sign_a;
   logic                 r_sign_b;
   logic                 r_zero_div;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic [WIDTH-1:0]     r_opnd;
   logic                 r_busy;
   logic                 r_done;
   logic [2*WIDTH-1:0]   r_result;

   logic                 w_neg_a;
   logic                 w_neg_b;
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic                 w_b_zero;
   logic                 w_skip_calc;
   logic [WIDTH-1:0]     w_step_hi;
   logic [WIDTH-1:0]     w_step_lo;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quo;
   logic [WIDTH-1:0]     w_rem;
   logic [2*WIDTH-1:0]   w_fix;

   assign w_neg_a     = signed_op & a[WIDTH-1];
   assign w_neg_b     = signed_op & b[WIDTH-1];
   assign w_mag_a     = w_neg_a ? -a : a;
   assign w_mag_b     = w_neg_b ? -b : b;
   assign w_b_zero    = (b == '0);
   // Single-cycle multiply and divide-by-zero skip CALC and go straight to the fix/register stage.
   assign w_skip_calc = (op_div == OP_DIV) ? w_b_zero : MUL_FAST;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op_div  (r_op_div),
      .hi      (r_hi),
      .lo      (r_lo),
      .opnd    (r_opnd),
      .hi_next (w_step_hi),
      .lo_next (w_step_lo)
   );

   generate
      if (MUL_FAST) begin : g_mul_fast
         assign w_prod = {{WIDTH{1'b0}}, r_opnd} * {{WIDTH{1'b0}}, r_lo};
      end else begin : g_mul_iter
         assign w_prod = {r_hi, r_lo};
      end
   endgenerate

   always_comb begin
      w_quo = (r_sign_a ^ r_sign_b) ? -r_lo : r_lo;
      w_rem = r_sign_a ? -r_hi : r_hi;
      if (r_zero_div) begin
         w_fix = {r_lo, {WIDTH{1'b1}}};
      end else if (r_op_div == OP_DIV) begin
         w_fix = {w_rem, w_quo};
      end else begin
         w_fix = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_op_div   <= 1'b0;
         r_sign_a   <= 1'b0;
         r_sign_b   <= 1'b0;
         r_zero_div <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_opnd     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_result   <= '0;
      end else if (annul && (r_state != S_IDLE)) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start && !annul) begin
                  r_op_div   <= op_div;
                  r_sign_a   <= w_neg_a;
                  r_sign_b   <= w_neg_b;
                  r_zero_div <= (op_div == OP_DIV) && w_b_zero;
                  r_count    <= '0;
                  r_hi       <= '0;
                  r_busy     <= 1'b1;
                  if (op_div == OP_DIV) begin
                     // A zero divisor reports the raw dividend, so keep it unmodified.
                     r_lo   <= w_b_zero ? a : w_mag_a;
                     r_opnd <= w_mag_b;
                  end else begin
                     r_lo   <= w_mag_b;
                     r_opnd <= w_mag_a;
                  end
                  r_state <= w_skip_calc ? S_FIX : S_CALC;
               end
            end
            S_CALC: begin
               r_hi    <= w_step_hi;
               r_lo    <= w_step_lo;
               r_count <= r_count + 1'b1;
               if (r_count == CNT_W'(WIDTH - 1)) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_result <= w_fix;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : randomized self-checking bench for both multiply variants  (rev 1.0)
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        op_div = 1'b0;
   logic        signed_op = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        annul = 1'b0;
   logic        busy_f, done_f, busy_s, done_s;
   logic [63:0] result_f, result_s;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] last_exp = '0;
   logic [63:0] res;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32), .MUL_FAST(1'b1)) dut_f (
      .clk(clk), .rst(rst), .start(start), .op_div(op_div), .signed_op(signed_op),
      .a(a), .b(b), .annul(annul), .busy(busy_f), .done(done_f), .result(result_f)
   );

   muldiv_unit #(.WIDTH(32), .MUL_FAST(1'b0)) dut_s (
      .clk(clk), .rst(rst), .start(start), .op_div(op_div), .signed_op(signed_op),
      .a(a), .b(b), .annul(annul), .busy(busy_s), .done(done_s), .result(result_s)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference results straight from integer arithmetic.
   function automatic logic [63:0] ref_model(input bit div, input bit sg,
                                             input logic [31:0] av, input logic [31:0] bv);
      logic [31:0] q, r;
      if (div) begin
         if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
         if (!sg) begin
            q = av / bv;
            r = av % bv;
         end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
         end else begin
            q = $signed(av) / $signed(bv);
            r = $signed(av) % $signed(bv);
         end
         return {r, q};
      end
      if (sg) return $signed({{32{av[31]}}, av}) * $signed({{32{bv[31]}}, bv});
      return {32'd0, av} * {32'd0, bv};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return 32'($urandom_range(0, 200));
         default: return $urandom;
      endcase
   endfunction

   // Starts an op in cycle 0 and watches both variants for 37 cycles.
   task automatic run_op(input bit div, input bit sg, input logic [31:0] av,
                         input logic [31:0] bv, input string tag, output logic [63:0] got);
      logic [63:0] exp, res_f, res_s;
      int          lat_f, lat_s, dc_f, dc_s, nd_f, nd_s;
      bit          bbad_f, bbad_s;
      exp    = ref_model(div, sg, av, bv);
      lat_s  = (div && bv == 32'd0) ? 2 : 34;
      lat_f  = ((div && bv == 32'd0) || !div) ? 2 : 34;
      dc_f   = -1;  dc_s = -1;  nd_f = 0;  nd_s = 0;
      bbad_f = 1'b0; bbad_s = 1'b0;
      res_f  = 'x;  res_s = 'x;
      start = 1'b1; op_div = div; signed_op = sg; a = av; b = bv;
      for (int cyc = 1; cyc <= 37; cyc++) begin
         @(posedge clk); #1;
         if (busy_f !== (cyc < lat_f)) bbad_f = 1'b1;
         if (busy_s !== (cyc < lat_s)) bbad_s = 1'b1;
         if (done_f === 1'b1) begin
            nd_f++;
            if (dc_f < 0) begin dc_f = cyc; res_f = result_f; end
         end
         if (done_s === 1'b1) begin
            nd_s++;
            if (dc_s < 0) begin dc_s = cyc; res_s = result_s; end
         end
         // Extra start while busy and scrambled operands must both be ignored.
         start     = (cyc < 2);
         a         = $urandom;
         b         = $urandom;
         op_div    = 1'($urandom);
         signed_op = 1'($urandom);
      end
      start = 1'b0;
      check({tag, "_done_cycle_f"}, 64'(dc_f), 64'(lat_f));
      check({tag, "_done_cycle_s"}, 64'(dc_s), 64'(lat_s));
      check({tag, "_result_f"}, res_f, exp);
      check({tag, "_result_s"}, res_s, exp);
      check({tag, "_busy_f"}, 64'(bbad_f), 64'd0);
      check({tag, "_busy_s"}, 64'(bbad_s), 64'd0);
      check({tag, "_done_pulses"}, 64'({nd_f[7:0], nd_s[7:0]}), 64'h0101);
      check({tag, "_hold"}, {result_f ^ exp} | {result_s ^ exp}, 64'd0);
      last_exp = exp;
      got      = res_f;
   endtask

   initial begin
      int nd;
      logic [31:0] ra, rb;
      bit          rd, rs;

      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {busy_f, busy_s}, 64'd0);
      check("reset_done", {done_f, done_s}, 64'd0);
      check("reset_result", result_f | result_s, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(1'b1, 1'b0, 32'd100, 32'd7, "udiv_100_7", res);
      check("udiv_100_7_const", res, {32'd2, 32'd14});
      run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, "sdiv_m7_2", res);
      check("sdiv_m7_2_const", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "sdiv_ovf", res);
      check("sdiv_ovf_const", res, {32'h0, 32'h8000_0000});
      run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, "smul_m3_5", res);
      check("smul_m3_5_const", res, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, "umul_max_2", res);
      check("umul_max_2_const", res, 64'h1_FFFF_FFFE);
      run_op(1'b1, 1'b0, 32'd5, 32'd0, "div_5_0", res);
      check("div_5_0_const", res, {32'd5, 32'hFFFF_FFFF});
      run_op(1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0, "sdiv_zero", res);

      // Annul mid-divide: no done, result unchanged.
      start = 1'b1; op_div = 1'b1; signed_op = 1'b0; a = 32'd1000; b = 32'd3;
      nd = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk); #1;
         if (done_f === 1'b1 || done_s === 1'b1) nd++;
         if (cyc == 11) check("annul_busy", {busy_f, busy_s}, 64'd0);
         start = 1'b0;
         annul = (cyc == 10);
      end
      check("annul_no_done", 64'(nd), 64'd0);
      check("annul_result_f", result_f, last_exp);
      check("annul_result_s", result_s, last_exp);

      // Annul together with start in IDLE: start ignored.
      start = 1'b1; annul = 1'b1; op_div = 1'b1; a = 32'd9; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; annul = 1'b0;
      check("annul_start_busy", {busy_f, busy_s}, 64'd0);
      nd = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(posedge clk); #1;
         if (done_f === 1'b1 || done_s === 1'b1) nd++;
      end
      check("annul_start_no_done", 64'(nd), 64'd0);
      run_op(1'b1, 1'b0, 32'd9, 32'd3, "udiv_9_3", res);
      check("udiv_9_3_const", res, {32'd0, 32'd3});

      // Reset mid-divide.
      start = 1'b1; op_div = 1'b1; signed_op = 1'b0; a = 32'd77; b = 32'd5;
      nd = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk); #1;
         if (done_f === 1'b1 || done_s === 1'b1) nd++;
         if (cyc == 6) begin
            check("midrst_busy", {busy_f, busy_s}, 64'd0);
            check("midrst_result", result_f | result_s, 64'd0);
         end
         start = 1'b0;
         rst   = (cyc == 5);
      end
      check("midrst_no_done", 64'(nd), 64'd0);
      last_exp = '0;

      for (int i = 0; i < 30; i++) begin
         rd = 1'($urandom);
         rs = 1'($urandom);
         ra = pick();
         rb = pick();
         run_op(rd, rs, ra, rb, $sformatf("rand%0d", i), res);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
